// File: rtl/ct_f_spsram_pkg.sv
// ct_f_spsram_pkg
// Shared definitions for the parametrised FPGA single-port SRAM wrapper.
// Contents:
//   spsram_state_e : wrapper FSM encoding (INIT sweeps zeros, RUN is normal access)
//   calc_nseg      : number of segment RAMs needed for a given data width
//   geometry_ok    : legality test used by the top-level elaboration check
package ct_f_spsram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } spsram_state_e;

  function automatic int calc_nseg(input int data_width, input int wrap_size);
    return data_width / wrap_size;
  endfunction

  // The data word must tile exactly into whole segment RAMs.
  function automatic bit geometry_ok(input int data_width, input int wrap_size);
    return (wrap_size > 0) && (data_width > 0) && ((data_width % wrap_size) == 0);
  endfunction

endpackage

// File: rtl/fpga_ram.sv
// fpga_ram
// Generic single-port block RAM for FPGA builds. Read-first behaviour: the
// output register always captures the word stored at the address before any
// write in the same cycle takes effect. No reset on the array or output.
// Ports:
//   PortAClk         in  clock
//   PortAAddr        in  ADDRWIDTH  address
//   PortADataIn      in  DATAWIDTH  write data
//   PortAWriteEnable in  write enable, active-high
//   PortADataOut     out DATAWIDTH  registered read data
module fpga_ram #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 10
) (
  input  logic                 PortAClk,
  input  logic [ADDRWIDTH-1:0] PortAAddr,
  input  logic [DATAWIDTH-1:0] PortADataIn,
  input  logic                 PortAWriteEnable,
  output logic [DATAWIDTH-1:0] PortADataOut
);

  logic [DATAWIDTH-1:0] mem [2**ADDRWIDTH];

  always_ff @(posedge PortAClk) begin
    if (PortAWriteEnable) begin
      mem[PortAAddr] <= PortADataIn;
    end
    PortADataOut <= mem[PortAAddr];
  end

endmodule

// File: rtl/ct_f_spsram_gen.sv
// ct_f_spsram_gen
// Parametrised FPGA single-port SRAM wrapper. Tiles DATA_WIDTH into
// DATA_WIDTH/WRAP_SIZE fpga_ram segments sharing one address, each with its
// own write enable. After reset every address is swept to zero before normal
// access is allowed; INIT_DONE reports when the sweep has finished.
// With CEN high the RAMs re-read the last accessed address so Q holds.
// Optional feature macro: CT_F_SPSRAM_OREG_EN adds an output register
// (read latency 2 instead of 1).
// Ports:
//   CLK        in  clock
//   RST        in  asynchronous active-high reset
//   A          in  ADDR_WIDTH  access address
//   CEN        in  chip enable, active-low
//   GWEN       in  global write enable, active-low
//   WEN        in  DATA_WIDTH  write mask, active-low; only the top bit of each segment is used
//   D          in  DATA_WIDTH  write data
//   Q          out DATA_WIDTH  read data, zero until INIT_DONE
//   INIT_DONE  out high once the zero sweep has completed
module ct_f_spsram_gen
  import ct_f_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 104,
  parameter int WRAP_SIZE  = 26
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  INIT_DONE
);

  localparam int NSEG = calc_nseg(DATA_WIDTH, WRAP_SIZE);

  if (!geometry_ok(DATA_WIDTH, WRAP_SIZE)) begin : g_geom_check
    $error("ct_f_spsram_gen: DATA_WIDTH must be a multiple of WRAP_SIZE");
  end

  spsram_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
  logic [ADDR_WIDTH-1:0] addr_holding_q, addr_holding_d;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [NSEG-1:0]       seg_we;
  logic [DATA_WIDTH-1:0] q_mux;
  logic                  in_init;

  // Only one WEN bit per segment is meaningful; the rest are deliberately dropped.
  logic unused_wen;
  assign unused_wen = ^WEN;

  assign in_init = (state_q == INIT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= INIT;
      init_addr_q    <= '0;
      addr_holding_q <= '0;
    end else begin
      state_q        <= state_d;
      init_addr_q    <= init_addr_d;
      addr_holding_q <= addr_holding_d;
    end
  end

  // Sweep counter wraps back to 0 as the last address is written, which is
  // also the edge on which the FSM enters RUN.
  always_comb begin
    state_d        = state_q;
    init_addr_d    = init_addr_q;
    addr_holding_d = addr_holding_q;
    case (state_q)
      INIT: begin
        init_addr_d = init_addr_q + ADDR_WIDTH'(1);
        if (init_addr_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!CEN) begin
          addr_holding_d = A;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Sweep owns the RAMs during INIT; afterwards CEN selects the live address
  // or the held one, so an idle RAM keeps re-reading the last access.
  always_comb begin
    ram_addr = addr_holding_q;
    ram_din  = D;
    seg_we   = '0;
    if (in_init) begin
      ram_addr = init_addr_q;
      ram_din  = '0;
      seg_we   = '1;
    end else begin
      if (!CEN) begin
        ram_addr = A;
      end
      for (int k = 0; k < NSEG; k++) begin
        seg_we[k] = !CEN && !GWEN && !WEN[k*WRAP_SIZE + WRAP_SIZE - 1];
      end
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    fpga_ram #(
      .DATAWIDTH (WRAP_SIZE),
      .ADDRWIDTH (ADDR_WIDTH)
    ) u_ram (
      .PortAClk         (CLK),
      .PortAAddr        (ram_addr),
      .PortADataIn      (ram_din[k*WRAP_SIZE +: WRAP_SIZE]),
      .PortAWriteEnable (seg_we[k]),
      .PortADataOut     (ram_q[k*WRAP_SIZE +: WRAP_SIZE])
    );
  end

  assign INIT_DONE = (state_q == RUN);
  assign q_mux     = INIT_DONE ? ram_q : '0;

`ifdef CT_F_SPSRAM_OREG_EN
  logic [DATA_WIDTH-1:0] q_q, q_d;

  assign q_d = q_mux;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;
`else
  assign Q = q_mux;
`endif

endmodule
